// File: rtl/mode_ctrl_pkg.sv
// Shared types and constants for the mode controller and its button classifiers.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    WAIT_REL = 2'd2
  } btn_state_e;

  localparam logic [2:0] MODE_CLOCK     = 3'd1;
  localparam logic [2:0] MODE_ALARM     = 3'd2;
  localparam logic [2:0] MODE_TIMER     = 3'd3;
  localparam logic [2:0] MODE_STOPWATCH = 3'd4;

  localparam int unsigned DEF_NUM_MODES    = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;
  localparam int unsigned DEF_LONG_CYC     = 50000000;
  localparam int unsigned DEF_IDLE_CYC     = 1500000000;

endpackage

// File: rtl/btn_press_classifier.sv
// One push-button: 2-FF synchroniser, debouncer and short/long press classifier.
module btn_press_classifier
  import mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic cancel,
  output logic short_p,
  output logic long_p,
  output logic pressed
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned LW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

  logic [1:0]    sync;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic [LW-1:0] hold_cnt;
  btn_state_e    state;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b00;
      db_level <= 1'b0;
      db_cnt   <= '0;
      hold_cnt <= '0;
      state    <= IDLE;
    end else begin
      sync <= {sync[0], btn_raw};

      // Level is accepted only after DEBOUNCE_CYC consecutive differing samples.
      if (sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        db_level <= sync[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      case (state)
        IDLE: begin
          if (db_level) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (cancel) begin
            state <= WAIT_REL;
          end else if (!db_level) begin
            state <= IDLE;
          end else if (hold_cnt == LW'(LONG_CYC - 1)) begin
            state <= WAIT_REL;
          end else begin
            hold_cnt <= hold_cnt + LW'(1);
          end
        end
        WAIT_REL: begin
          if (!db_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses decode registered state so the parent can register them with one cycle of latency.
  assign short_p = (state == PRESSED) && !db_level;
  assign long_p  = (state == PRESSED) && db_level && (hold_cnt == LW'(LONG_CYC - 1));
  assign pressed = db_level;

endmodule

// File: rtl/mode_controller.sv
// Sequences operating modes from the MODE button and routes ACTION presses as B_S/B_L.
// Optional inactivity return to mode 1 when MODE_CTRL_AUTO_RETURN_EN is defined.
module mode_controller
  import mode_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MODES    = DEF_NUM_MODES,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned IDLE_CYC     = DEF_IDLE_CYC
) (
  input  logic                 clk_50MHz,
  input  logic                 rst_n,
  input  logic                 btn_mode_raw,
  input  logic                 btn_act_raw,
  output logic [2:0]           mode_sel,
  output logic [NUM_MODES-1:0] En,
  output logic                 B_S,
  output logic                 B_L
);

  logic       mode_short, mode_long, mode_pressed;
  logic       act_short, act_long, act_pressed;
  logic       mode_chg_c;
  logic       idle_hit_c;
  logic [2:0] mode_next_c;

  btn_press_classifier #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC)
  ) u_mode_btn (
    .clk_50MHz(clk_50MHz),
    .rst_n    (rst_n),
    .btn_raw  (btn_mode_raw),
    .cancel   (1'b0),
    .short_p  (mode_short),
    .long_p   (mode_long),
    .pressed  (mode_pressed)
  );

  // A mode change cancels an in-progress ACTION press so it never lands in the new mode.
  btn_press_classifier #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC)
  ) u_act_btn (
    .clk_50MHz(clk_50MHz),
    .rst_n    (rst_n),
    .btn_raw  (btn_act_raw),
    .cancel   (mode_chg_c),
    .short_p  (act_short),
    .long_p   (act_long),
    .pressed  (act_pressed)
  );

`ifdef MODE_CTRL_AUTO_RETURN_EN
  localparam int unsigned IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

  logic [IW-1:0] idle_cnt;
  logic          mode_q, act_q;
  logic          any_edge_c;

  assign any_edge_c = (mode_q != mode_pressed) || (act_q != act_pressed);
  assign idle_hit_c = (idle_cnt == IW'(IDLE_CYC - 1)) && (mode_sel != MODE_CLOCK) &&
                      !mode_pressed && !act_pressed;

  // Inactivity counter: frozen while a button is held, saturates when already in mode 1.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      mode_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      mode_q <= mode_pressed;
      act_q  <= act_pressed;
      if (any_edge_c || idle_hit_c) begin
        idle_cnt <= '0;
      end else if (!mode_pressed && !act_pressed && (idle_cnt != IW'(IDLE_CYC - 1))) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end
`else
  logic unused_pressed;
  assign unused_pressed = mode_pressed | act_pressed;
  assign idle_hit_c     = 1'b0;
`endif

  always_comb begin
    mode_chg_c  = 1'b0;
    mode_next_c = mode_sel;
    if (mode_long) begin
      mode_chg_c  = 1'b1;
      mode_next_c = MODE_CLOCK;
    end else if (mode_short) begin
      mode_chg_c  = 1'b1;
      mode_next_c = (mode_sel == 3'(NUM_MODES)) ? MODE_CLOCK : mode_sel + 3'd1;
    end else if (idle_hit_c) begin
      mode_chg_c  = 1'b1;
      mode_next_c = MODE_CLOCK;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_sel <= MODE_CLOCK;
      En       <= NUM_MODES'(1);
      B_S      <= 1'b0;
      B_L      <= 1'b0;
    end else begin
      mode_sel <= mode_next_c;
      En       <= NUM_MODES'(1) << (mode_next_c - 3'd1);
      B_S      <= act_short && !mode_chg_c;
      B_L      <= act_long && !mode_chg_c;
    end
  end

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with a pulse scoreboard; DEBOUNCE=4, LONG=20, IDLE=100.
`timescale 1ns/1ps
module tb_mode_controller;

  localparam int unsigned NM = 4;

  logic          clk_50MHz = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_mode_raw = 1'b0;
  logic          btn_act_raw = 1'b0;
  logic [2:0]    mode_sel;
  logic [NM-1:0] En;
  logic          B_S, B_L;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bl_cyc = -1;
  int pulse_cnt = 0;
  logic [1:0] exp_q[$];
  logic [2:0] exp_mode;

  always #10 clk_50MHz = ~clk_50MHz;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  mode_controller #(
    .NUM_MODES   (NM),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .IDLE_CYC    (100)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst_n       (rst_n),
    .btn_mode_raw(btn_mode_raw),
    .btn_act_raw (btn_act_raw),
    .mode_sel    (mode_sel),
    .En          (En),
    .B_S         (B_S),
    .B_L         (B_L)
  );

  // Every observed pulse must match the oldest expected one ({B_L,B_S}: 01 short, 10 long).
  always @(negedge clk_50MHz) begin
    if (B_S || B_L) begin
      logic [1:0] obs;
      logic [1:0] exp;
      obs = {B_L, B_S};
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        exp = 2'b00;
      end else begin
        exp = exp_q.pop_front();
      end
      assert (obs === exp) else begin
        errors++;
        $error("FAIL pulse at cycle %0d: observed %b expected %b", cyc, obs, exp);
      end
      if (B_L) bl_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic check_mode(input string tag);
    logic [NM-1:0] exp_en;
    exp_en = NM'(1) << (exp_mode - 3'd1);
    chk({tag, "_sel"}, int'(mode_sel), int'(exp_mode));
    chk({tag, "_en"}, int'(En), int'(exp_en));
  endtask

  task automatic mode_short_press();
    btn_mode_raw = 1'b1;
    idle(10);
    btn_mode_raw = 1'b0;
    idle(12);
    exp_mode = (exp_mode == 3'(NM)) ? 3'd1 : exp_mode + 3'd1;
  endtask

  initial begin
    int p0;
    int lat;

    // Reset values
    idle(3);
    exp_mode = 3'd1;
    check_mode("reset");
    chk("reset_bs", int'(B_S), 0);
    chk("reset_bl", int'(B_L), 0);
    rst_n = 1'b1;
    idle(2);

    // Four MODE short presses walk 2,3,4,1
    for (int i = 0; i < 4; i++) begin
      mode_short_press();
      check_mode($sformatf("mode_step%0d", i));
    end

    // ACTION short press
    exp_q.push_back(2'b01);
    btn_act_raw = 1'b1;
    idle(10);
    btn_act_raw = 1'b0;
    idle(12);
    chk("short_drained", exp_q.size(), 0);

    // ACTION long press: fires while held, nothing on release
    exp_q.push_back(2'b10);
    btn_act_raw = 1'b1;
    p0 = cyc;
    idle(40);
    btn_act_raw = 1'b0;
    idle(15);
    chk("long_drained", exp_q.size(), 0);
    lat = bl_cyc - p0;
    chk("long_latency", lat, 27);

    // Bounce glitches followed by a stable press give exactly one short
    exp_q.push_back(2'b01);
    repeat (2) begin
      btn_act_raw = 1'b1; idle(2);
      btn_act_raw = 1'b0; idle(2);
    end
    btn_act_raw = 1'b1;
    idle(10);
    btn_act_raw = 1'b0;
    idle(14);
    chk("bounce_drained", exp_q.size(), 0);

    // Glitches alone give nothing
    p0 = pulse_cnt;
    repeat (3) begin
      btn_act_raw = 1'b1; idle(2);
      btn_act_raw = 1'b0; idle(2);
    end
    idle(15);
    chk("glitch_only_pulses", pulse_cnt - p0, 0);

    // MODE short during an ACTION hold cancels the ACTION press
    p0 = pulse_cnt;
    btn_act_raw = 1'b1;
    idle(2);
    mode_short_press();
    btn_act_raw = 1'b0;
    idle(15);
    check_mode("cancel");
    chk("cancel_pulses", pulse_cnt - p0, 0);

    // MODE long returns to mode 1 at the threshold, not on release
    mode_short_press();
    check_mode("pre_long");
    btn_mode_raw = 1'b1;
    idle(20);
    check_mode("long_hold_early");
    idle(10);
    exp_mode = 3'd1;
    check_mode("long_hold_fired");
    btn_mode_raw = 1'b0;
    idle(15);
    check_mode("long_released");

    // Asynchronous reset mid ACTION press
    mode_short_press();
    check_mode("pre_reset");
    p0 = pulse_cnt;
    btn_act_raw = 1'b1;
    idle(10);
    #5 rst_n = 1'b0;
    #1;
    exp_mode = 3'd1;
    check_mode("async_reset");
    chk("async_reset_bs", int'(B_S), 0);
    chk("async_reset_bl", int'(B_L), 0);
    @(negedge clk_50MHz);
    btn_act_raw = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(30);
    chk("after_reset_pulses", pulse_cnt - p0, 0);
    check_mode("after_reset");

    // Idle in mode 4
    for (int i = 0; i < 3; i++) mode_short_press();
    check_mode("pre_idle");
    idle(130);
`ifdef MODE_CTRL_AUTO_RETURN_EN
    exp_mode = 3'd1;
`else
    exp_mode = 3'd4;
`endif
    check_mode("idle");
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
